f32_mult_issue_ctrl: RTL and testbench

//  Upstream issue/collect stage for the f32_mult start/done multiplier.
//  - Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
//  - Issues one multiply at a time, holding mul_a/mul_b stable until mul_done.
//  - Returns the product on a valid/ready stream; a watchdog flags a hung multiplier.

---
 rtl/f32_mult_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_f32_mult_issue_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f32_mult_issue_ctrl.sv
// ---------------------------------------------------------------------------
// f32_mult_issue_ctrl
//
// Issue/collect stage in front of a start/done f32 multiplier.
//   * Operand pairs arrive on a valid/ready stream and are buffered in a
//     DEPTH-entry FIFO.
//   * One multiply is in flight at a time. mul_a/mul_b are registered and do
//     not change until the op completes or is abandoned.
//   * The product leaves on a valid/ready stream.
//   * A watchdog abandons an op whose mul_done never arrives and raises a
//     sticky timeout_err.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds valid and data stable
// until that edge. ready may be asserted independently of valid.
//
// Parameters
//   DEPTH    operand FIFO entries (power of 2, >= 2)
//   TIMEOUT  cycles from mul_start until the op is abandoned (>= 8)
//   CNT_W    width of op_count
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand stream handshake (in_ready = FIFO not full)
//   in_a, in_b           operands, IEEE-754 single
//   out_valid/out_ready  product stream handshake
//   out_p                product
//   mul_start            one-cycle start pulse to the multiplier
//   mul_a, mul_b         registered operands to the multiplier
//   mul_done, mul_p      multiplier completion pulse and result
//   busy                 FSM active or FIFO non-empty
//   timeout_err          sticky watchdog error, cleared by err_clr
//   err_clr              clears timeout_err
//   op_count             delivered products (output handshakes), wraps
//   state_dbg            current FSM state (0 idle, 1 start, 2 wait, 3 out)
// ---------------------------------------------------------------------------
module f32_mult_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_p,
    output logic             mul_start,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic             mul_done,
    input  logic [31:0]      mul_p,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       state_dbg
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_FW = PTR_W + 1;
    localparam int WD_W   = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [31:0]       mem_a [DEPTH];
    logic [31:0]       mem_b [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_FW-1:0] count;
    logic [CNT_FW-1:0] count_nxt;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // in_ready is a register so it stays low throughout reset and rises one
    // cycle after release. It is derived from the count as it will be after
    // this edge, so it reads "not full" for the current contents and ignores
    // any pop happening in the same cycle.
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count == '0);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_FW'(1);
            2'b01:   count_nxt = count - CNT_FW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nxt;
            in_ready <= (count_nxt != CNT_FW'(DEPTH));
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    // The compare looks at the incremented value, so the start cycle counts
    // as the first watchdog cycle and timeout_err becomes visible exactly
    // TIMEOUT cycles after mul_start.
    logic [WD_W-1:0] wd;
    logic [WD_W-1:0] wd_inc;
    logic            wd_hit;

    assign wd_inc = wd + WD_W'(1);
    assign wd_hit = (wd_inc == WD_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!fifo_empty) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                // A done arriving on the timeout cycle still completes the op.
                if (mul_done)    state_nxt = S_OUT;
                else if (wd_hit) state_nxt = S_IDLE;
            end
            S_OUT:   if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // ------------------------------------------------------------------
    logic wd_clear;
    logic wd_run;
    logic capture;
    logic wd_fire;
    logic deliver;

    always_comb begin
        pop       = 1'b0;
        mul_start = 1'b0;
        wd_clear  = 1'b0;
        wd_run    = 1'b0;
        capture   = 1'b0;
        wd_fire   = 1'b0;
        deliver   = 1'b0;
        case (state)
            S_IDLE:  pop = !fifo_empty;
            S_START: begin
                mul_start = 1'b1;
                wd_clear  = 1'b1;
            end
            S_WAIT: begin
                wd_run = 1'b1;
                if (mul_done)    capture = 1'b1;
                else if (wd_hit) wd_fire = 1'b1;
            end
            S_OUT:   deliver = out_ready;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Operands are loaded only on a pop, which keeps them stable across the
    // whole START/WAIT/OUT sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (pop) begin
            mul_a <= mem_a[rd_ptr];
            mul_b <= mem_b[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        wd <= '0;
        else if (wd_clear) wd <= '0;
        else if (wd_run)   wd <= wd_inc;
    end

    // mul_p is only meaningful while mul_done is high in S_WAIT; any other
    // mul_done pulse is ignored because capture is gated by the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p     <= '0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else if (capture) begin
            out_p     <= mul_p;
            out_valid <= 1'b1;
        end else if (deliver) begin
            out_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
        end
    end

    // A fresh timeout beats a simultaneous clear so the event is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       timeout_err <= 1'b0;
        else if (wd_fire) timeout_err <= 1'b1;
        else if (err_clr) timeout_err <= 1'b0;
    end

    assign busy      = (state != S_IDLE) || !fifo_empty;
    assign state_dbg = state;

endmodule

// File: tb/tb_f32_mult_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_f32_mult_issue_ctrl
//
// Directed bench for f32_mult_issue_ctrl. A behavioural multiplier stub
// answers mul_start after 4 cycles (3 for zero/inf/NaN operands) with a
// product looked up from a small table of hand-computed pairs, or never
// answers when hang=1. A negedge monitor checks every delivered product
// against the expected queue, out_p stability under backpressure and
// op_count against the handshakes it has observed.
// ---------------------------------------------------------------------------
module tb_f32_mult_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_p;
  logic             mul_start;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic             mul_done;
  logic [31:0]      mul_p;
  logic             busy;
  logic             timeout_err;
  logic             err_clr;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       state_dbg;

  logic             hang = 1'b0;
  logic             stray_done = 1'b0;
  logic             stub_done = 1'b0;
  logic [31:0]      stub_p = 32'h0;

  assign mul_done = stub_done | stray_done;
  assign mul_p    = stub_p;

  f32_mult_issue_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_p       (out_p),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_p       (mul_p),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .op_count    (op_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int n_hs = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- multiplier stub ----------------
  function automatic logic [31:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40400000, 32'h40000000}: return 32'h40C00000;
      {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
      {32'h00000000, 32'h40490FDB}: return 32'h00000000;
      {32'h7F800000, 32'h40000000}: return 32'h7F800000;
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
      {32'h40000000, 32'h40800000}: return 32'h41000000;
      {32'hC0000000, 32'h40400000}: return 32'hC0C00000;
      {32'h3F000000, 32'h3F000000}: return 32'h3E800000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic bit is_special(input logic [31:0] x);
    return (x[30:0] == 31'h0) || (x[30:23] == 8'hFF);
  endfunction

  initial begin : mult_stub
    int lat;
    logic [31:0] p;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mul_start && !hang) begin
        lat = (is_special(mul_a) || is_special(mul_b)) ? 3 : 4;
        p = stub_mul(mul_a, mul_b);
        repeat (lat) @(posedge clk);
        #1;
        stub_done = 1'b1;
        stub_p    = p;
        @(posedge clk); #1;
        stub_done = 1'b0;
        stub_p    = 32'h0;
      end
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  logic        prev_valid = 1'b0;
  logic [31:0] prev_p = 32'h0;
  logic        prev_hs = 1'b0;

  always @(negedge clk) begin : monitor
    logic hs;
    if (!rst_n) begin
      n_hs       = 0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      check32("op_count_track", 32'(op_count), 32'(n_hs));
      if (out_valid && prev_valid && !prev_hs)
        check32("out_p_stable", out_p, prev_p);
      hs = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%08h, expected no product at %0t", out_p, $time);
        end else begin
          check32("out_p", out_p, exp_q.pop_front());
        end
        n_hs++;
      end
      prev_valid = out_valid;
      prev_p     = out_p;
      prev_hs    = hs;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input bit expect_out);
    int n;
    bit accepted;
    n = 0;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      else n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (accepted) begin
      if (expect_out) exp_q.push_back(p);
    end else begin
      checks++;
      errors++;
      $display("FAIL push_accept: in_ready stayed 0, expected accept within 200 cycles");
    end
  endtask

  task automatic wait_start();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (mul_start) seen = 1'b1;
    end
    check32("mul_start_seen", 32'(seen), 32'd1);
  endtask

  task automatic cycles_to_valid(output int k);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (out_valid) return;
    end
    k = -1;
  endtask

  task automatic cycles_to_err(output int k);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (timeout_err) return;
    end
    k = -1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (n < max_cycles && (exp_q.size() != 0 || busy || out_valid)) begin
      @(negedge clk);
      n++;
    end
    check32("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_in_ready"},    32'(in_ready),    32'd0);
    check32({tag, "_out_valid"},   32'(out_valid),   32'd0);
    check32({tag, "_out_p"},       out_p,            32'd0);
    check32({tag, "_mul_start"},   32'(mul_start),   32'd0);
    check32({tag, "_mul_a"},       mul_a,            32'd0);
    check32({tag, "_mul_b"},       mul_b,            32'd0);
    check32({tag, "_busy"},        32'(busy),        32'd0);
    check32({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check32({tag, "_op_count"},    32'(op_count),    32'd0);
    check32({tag, "_state"},       32'(state_dbg),   32'(ST_IDLE));
  endtask

  // ---------------- global guard ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- main test ----------------
  initial begin
    int k;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b1;
    err_clr   = 1'b0;

    vecs[0] = '{32'h40400000, 32'h40000000, 32'h40C00000, 5};
    vecs[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 5};
    vecs[2] = '{32'h00000000, 32'h40490FDB, 32'h00000000, 4};
    vecs[3] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 4};
    vecs[4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5};
    vecs[5] = '{32'h40000000, 32'h40800000, 32'h41000000, 5};
    vecs[6] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 5};
    vecs[7] = '{32'h3F000000, 32'h3F000000, 32'h3E800000, 5};

    // Reset state and in_ready rising one cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check32("in_ready_release_cycle", 32'(in_ready), 32'd0);
    @(negedge clk);
    check32("in_ready_after_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Table: one op at a time, start-to-valid latency and operand routing.
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);
      wait_start();
      check32("mul_a_issue", mul_a, vecs[i].a);
      check32("mul_b_issue", mul_b, vecs[i].b);
      cycles_to_valid(k);
      check32("start_to_valid", 32'(k), 32'(vecs[i].lat));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check32("op_count_table", 32'(op_count), 32'd8);
    @(posedge clk); #1;

    // Back-to-back pairs, delivered in order.
    push(vecs[1].a, vecs[1].b, vecs[1].p, 1'b1);
    push(vecs[2].a, vecs[2].b, vecs[2].p, 1'b1);
    push(vecs[3].a, vecs[3].b, vecs[3].p, 1'b1);
    wait_drain(200);
    @(negedge clk);
    check32("op_count_b2b", 32'(op_count), 32'd11);
    @(posedge clk); #1;

    // Backpressure: one op parked in S_OUT plus DEPTH queued fills the block.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);
    in_valid = 1'b1;
    in_a = vecs[5].a;
    in_b = vecs[5].b;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check32("bp_in_ready", 32'(in_ready), 32'd0);
    check32("bp_state", 32'(state_dbg), 32'(ST_OUT));
    check32("bp_out_valid", 32'(out_valid), 32'd1);
    check32("bp_out_p", out_p, vecs[0].p);
    check32("bp_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    push(vecs[5].a, vecs[5].b, vecs[5].p, 1'b1);
    wait_drain(300);
    @(negedge clk);
    check32("op_count_bp", 32'(op_count), 32'd17);
    @(posedge clk); #1;

    // Watchdog: hung multiplier.
    hang = 1'b1;
    push(vecs[0].a, vecs[0].b, 32'h0, 1'b0);
    wait_start();
    cycles_to_err(k);
    check32("timeout_latency", 32'(k), 32'(TIMEOUT));
    check32("timeout_no_valid", 32'(out_valid), 32'd0);
    check32("timeout_state", 32'(state_dbg), 32'(ST_IDLE));
    check32("timeout_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check32("timeout_sticky", 32'(timeout_err), 32'd1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check32("err_clr", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;

    // Timeout coinciding with a held err_clr still sets the flag.
    err_clr = 1'b1;
    push(vecs[1].a, vecs[1].b, 32'h0, 1'b0);
    wait_start();
    cycles_to_err(k);
    check32("timeout_vs_clr", 32'(k), 32'(TIMEOUT));
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check32("err_clr_second", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;

    // Normal op after the watchdog episodes.
    hang = 1'b0;
    push(vecs[4].a, vecs[4].b, vecs[4].p, 1'b1);
    wait_drain(100);
    @(negedge clk);
    check32("op_count_after_to", 32'(op_count), 32'd18);
    @(posedge clk); #1;

    // Reset while in S_WAIT with two entries queued.
    push(vecs[6].a, vecs[6].b, vecs[6].p, 1'b1);
    push(vecs[7].a, vecs[7].b, vecs[7].p, 1'b1);
    push(vecs[5].a, vecs[5].b, vecs[5].p, 1'b1);
    @(negedge clk);
    check32("pre_reset_state", 32'(state_dbg), 32'(ST_WAIT));
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check32("post_reset_busy", 32'(busy), 32'd0);
    check32("post_reset_valid", 32'(out_valid), 32'd0);

    // A stray mul_done while idle is ignored.
    @(posedge clk); #1;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    @(negedge clk);
    check32("stray_done_valid", 32'(out_valid), 32'd0);
    check32("stray_done_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk); #1;

    push(vecs[2].a, vecs[2].b, vecs[2].p, 1'b1);
    wait_drain(100);
    @(negedge clk);
    check32("op_count_post_reset", 32'(op_count), 32'd1);
    @(posedge clk); #1;

    // out_ready toggling: out_p held, op_count moves only on handshakes.
    out_ready = 1'b0;
    push(vecs[6].a, vecs[6].b, vecs[6].p, 1'b1);
    push(vecs[7].a, vecs[7].b, vecs[7].p, 1'b1);
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 3 == 2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain(100);
    @(negedge clk);
    check32("op_count_toggle", 32'(op_count), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
